// File: rtl/rle_stream_addr_ctrl_pkg.sv
// Shared widths, helpers and pointer-command encoding for the RLE flash stream sequencer.
package rle_stream_addr_ctrl_pkg;

   typedef logic [2:0] cmd_t;

   // Pointer update sources, listed from lowest to highest priority
   localparam cmd_t CMD_NONE     = 3'd0;
   localparam cmd_t CMD_INC      = 3'd1;
   localparam cmd_t CMD_LOAD_REL = 3'd2;
   localparam cmd_t CMD_LOAD_ABS = 3'd3;
   localparam cmd_t CMD_CLEAR    = 3'd4;

   function automatic int aw_of(int addr_bits, int word_bytes);
      return addr_bits - $clog2(word_bytes);
   endfunction

   function automatic int sw_of(int num_slots);
      return (num_slots <= 2) ? 1 : $clog2(num_slots);
   endfunction

   function automatic int word_shift(int word_bytes);
      return $clog2(word_bytes);
   endfunction

endpackage

// File: rtl/rle_stream_addr_ctrl_if.sv
// Request/response bundle between rle_video, the SPI flash path and the address sequencer.
interface rle_stream_addr_ctrl_if #(
   parameter int ADDR_BITS   = 24,
   parameter int WORD_BYTES  = 2,
   parameter int NUM_SLOTS   = 4,
   parameter int OFFSET_BITS = 8
);
   localparam int AW = rle_stream_addr_ctrl_pkg::aw_of(ADDR_BITS, WORD_BYTES);
   localparam int SW = rle_stream_addr_ctrl_pkg::sw_of(NUM_SLOTS);

   logic                   read_next;
   logic                   stop_read;
   logic                   clear_addr;
   logic [AW-1:0]          base_addr;
   logic                   save_abs;
   logic [SW-1:0]          save_slot;
   logic                   load_abs;
   logic [SW-1:0]          load_slot;
   logic                   mark_rel;
   logic                   load_rel;
   logic                   spi_busy;
   logic                   buf_empty;
   logic                   spi_start_read;
   logic                   spi_continue_read;
   logic [ADDR_BITS-1:0]   flash_addr;
   logic                   data_ready;
   logic                   started;
   logic [OFFSET_BITS-1:0] rel_off;

   modport master (
      output read_next, stop_read, clear_addr, base_addr, save_abs, save_slot,
             load_abs, load_slot, mark_rel, load_rel, spi_busy, buf_empty,
      input  spi_start_read, spi_continue_read, flash_addr, data_ready, started, rel_off
   );

   modport slave (
      input  read_next, stop_read, clear_addr, base_addr, save_abs, save_slot,
             load_abs, load_slot, mark_rel, load_rel, spi_busy, buf_empty,
      output spi_start_read, spi_continue_read, flash_addr, data_ready, started, rel_off
   );

endinterface

// File: rtl/rle_stream_addr_ctrl_slots.sv
// Bookmark register file: one write port, one combinational read port, read-before-write.
module rle_stream_addr_ctrl_slots #(
   parameter int NUM_SLOTS = 4,
   parameter int AW        = 23,
   parameter int SW        = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_we,
   input  logic [SW-1:0] i_waddr,
   input  logic [AW-1:0] i_wdata,
   input  logic [SW-1:0] i_raddr,
   output logic [AW-1:0] o_rdata,
   output logic          o_hit
);

   logic [AW-1:0] r_mem [NUM_SLOTS];

   // Indices beyond NUM_SLOTS match no slot, so those writes vanish and reads miss
   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                              r_mem[g] <= '0;
         else if (i_clr)                          r_mem[g] <= '0;
         else if (i_we && (i_waddr == SW'(g)))    r_mem[g] <= i_wdata;
      end
   end

   always_comb begin
      o_rdata = '0;
      o_hit   = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (i_raddr == SW'(i)) begin
            o_rdata = r_mem[i];
            o_hit   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rle_stream_addr_ctrl.sv
// Flash word-pointer sequencer: start/continue handshake, bookmarks and saturating rewind counter.
module rle_stream_addr_ctrl
   import rle_stream_addr_ctrl_pkg::*;
#(
   parameter int ADDR_BITS   = 24,
   parameter int WORD_BYTES  = 2,
   parameter int NUM_SLOTS   = 4,
   parameter int OFFSET_BITS = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   rle_stream_addr_ctrl_if.slave bus
);

   localparam int AW         = aw_of(ADDR_BITS, WORD_BYTES);
   localparam int SW         = sw_of(NUM_SLOTS);
   localparam int WORD_SHIFT = word_shift(WORD_BYTES);

   logic [AW-1:0]          r_ptr;
   logic [AW-1:0]          w_ptr_nxt;
   logic [AW-1:0]          w_slot_rdata;
   logic                   w_slot_hit;
   logic                   r_started;
   logic [OFFSET_BITS-1:0] r_rel_off;
   logic                   w_start;
   logic                   w_cont;
   cmd_t                   w_cmd;

   assign w_start = bus.read_next & ~r_started;
   assign w_cont  = bus.read_next &  r_started;

   assign bus.spi_start_read    = w_start;
   assign bus.spi_continue_read = w_cont;
   assign bus.flash_addr        = ADDR_BITS'(r_ptr) << WORD_SHIFT;
   assign bus.data_ready        = r_started & (~bus.spi_busy | ~bus.buf_empty) & ~bus.read_next;
   assign bus.started           = r_started;
   assign bus.rel_off           = r_rel_off;

   rle_stream_addr_ctrl_slots #(
      .NUM_SLOTS (NUM_SLOTS),
      .AW        (AW),
      .SW        (SW)
   ) u_slots (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (bus.clear_addr),
      .i_we    (bus.save_abs),
      .i_waddr (bus.save_slot),
      .i_wdata (r_ptr - AW'(1)),
      .i_raddr (bus.load_slot),
      .o_rdata (w_slot_rdata),
      .o_hit   (w_slot_hit)
   );

   // A load from a missing slot drops through to rewind/increment
   always_comb begin
      w_cmd = CMD_NONE;
      if (bus.clear_addr)                  w_cmd = CMD_CLEAR;
      else if (bus.load_abs && w_slot_hit) w_cmd = CMD_LOAD_ABS;
      else if (bus.load_rel)               w_cmd = CMD_LOAD_REL;
      else if (w_cont)                     w_cmd = CMD_INC;
   end

   always_comb begin
      w_ptr_nxt = r_ptr;
      case (w_cmd)
         CMD_CLEAR:    w_ptr_nxt = bus.base_addr;
         CMD_LOAD_ABS: w_ptr_nxt = w_slot_rdata;
         CMD_LOAD_REL: w_ptr_nxt = r_ptr - AW'(r_rel_off);
         CMD_INC:      w_ptr_nxt = r_ptr + AW'(1);
         default:      w_ptr_nxt = r_ptr;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ptr <= '0;
      else        r_ptr <= w_ptr_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             r_started <= 1'b0;
      else if (bus.stop_read) r_started <= 1'b0;
      else if (bus.read_next) r_started <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_rel_off <= '0;
      else if (bus.clear_addr)             r_rel_off <= '0;
      else if (bus.mark_rel)               r_rel_off <= OFFSET_BITS'(1);
      else if (w_cont && (r_rel_off != '1)) r_rel_off <= r_rel_off + OFFSET_BITS'(1);
   end

endmodule

// File: tb/tb_rle_stream_addr_ctrl.sv
// Directed bench: default-parameter instance plus a 3-slot, 2-bit-offset instance.
module tb_rle_stream_addr_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   rle_stream_addr_ctrl_if #(.ADDR_BITS(24), .WORD_BYTES(2), .NUM_SLOTS(4), .OFFSET_BITS(8)) ba ();
   rle_stream_addr_ctrl_if #(.ADDR_BITS(24), .WORD_BYTES(2), .NUM_SLOTS(3), .OFFSET_BITS(2)) bb ();

   rle_stream_addr_ctrl #(.ADDR_BITS(24), .WORD_BYTES(2), .NUM_SLOTS(4), .OFFSET_BITS(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ba.slave));

   rle_stream_addr_ctrl #(.ADDR_BITS(24), .WORD_BYTES(2), .NUM_SLOTS(3), .OFFSET_BITS(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bb.slave));

   always #5 clk = ~clk;

   task automatic clear_strobes();
      ba.read_next = 0; ba.stop_read = 0; ba.clear_addr = 0; ba.save_abs = 0;
      ba.load_abs = 0; ba.mark_rel = 0; ba.load_rel = 0;
      bb.read_next = 0; bb.stop_read = 0; bb.clear_addr = 0; bb.save_abs = 0;
      bb.load_abs = 0; bb.mark_rel = 0; bb.load_rel = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clear_strobes();
   endtask

   task automatic test_reset();
      clear_strobes();
      ba.base_addr = '0; ba.save_slot = '0; ba.load_slot = '0; ba.spi_busy = 0; ba.buf_empty = 0;
      bb.base_addr = '0; bb.save_slot = '0; bb.load_slot = '0; bb.spi_busy = 0; bb.buf_empty = 0;
      rst_n = 0;
      #12;
      total++; if (ba.spi_start_read !== 1'b0) begin bad++; $display("FAIL reset_start got=%0h exp=0", ba.spi_start_read); end
      total++; if (ba.spi_continue_read !== 1'b0) begin bad++; $display("FAIL reset_cont got=%0h exp=0", ba.spi_continue_read); end
      total++; if (ba.flash_addr !== 24'h0) begin bad++; $display("FAIL reset_flash_addr got=%0h exp=0", ba.flash_addr); end
      total++; if (ba.data_ready !== 1'b0) begin bad++; $display("FAIL reset_data_ready got=%0h exp=0", ba.data_ready); end
      total++; if (ba.started !== 1'b0) begin bad++; $display("FAIL reset_started got=%0h exp=0", ba.started); end
      total++; if (ba.rel_off !== 8'h0) begin bad++; $display("FAIL reset_rel_off got=%0h exp=0", ba.rel_off); end
      total++; if (bb.rel_off !== 2'h0) begin bad++; $display("FAIL reset_b_rel_off got=%0h exp=0", bb.rel_off); end
      @(negedge clk);
      rst_n = 1;
      step();
      total++; if (ba.started !== 1'b0) begin bad++; $display("FAIL post_reset_started got=%0h exp=0", ba.started); end
   endtask

   task automatic test_start_continue();
      ba.read_next = 1; #1;
      total++; if (ba.spi_start_read !== 1'b1) begin bad++; $display("FAIL first_start got=%0h exp=1", ba.spi_start_read); end
      total++; if (ba.spi_continue_read !== 1'b0) begin bad++; $display("FAIL first_cont got=%0h exp=0", ba.spi_continue_read); end
      total++; if (ba.flash_addr !== 24'h0) begin bad++; $display("FAIL first_addr got=%0h exp=0", ba.flash_addr); end
      step();
      ba.read_next = 1; #1;
      total++; if (ba.spi_continue_read !== 1'b1) begin bad++; $display("FAIL second_cont got=%0h exp=1", ba.spi_continue_read); end
      total++; if (ba.spi_start_read !== 1'b0) begin bad++; $display("FAIL second_start got=%0h exp=0", ba.spi_start_read); end
      step();
      ba.read_next = 1;
      step();
      total++; if (ba.flash_addr !== 24'h4) begin bad++; $display("FAIL three_reads_addr got=%0h exp=4", ba.flash_addr); end
      total++; if (ba.started !== 1'b1) begin bad++; $display("FAIL three_reads_started got=%0h exp=1", ba.started); end
      total++; if (ba.rel_off !== 8'h2) begin bad++; $display("FAIL three_reads_rel got=%0h exp=2", ba.rel_off); end
      ba.spi_busy = 1; ba.buf_empty = 0; #1;
      total++; if (ba.data_ready !== 1'b1) begin bad++; $display("FAIL dr_busy_nonempty got=%0h exp=1", ba.data_ready); end
      ba.buf_empty = 1; #1;
      total++; if (ba.data_ready !== 1'b0) begin bad++; $display("FAIL dr_busy_empty got=%0h exp=0", ba.data_ready); end
      ba.spi_busy = 0; #1;
      total++; if (ba.data_ready !== 1'b1) begin bad++; $display("FAIL dr_idle_empty got=%0h exp=1", ba.data_ready); end
      ba.read_next = 1; #1;
      total++; if (ba.data_ready !== 1'b0) begin bad++; $display("FAIL dr_during_read got=%0h exp=0", ba.data_ready); end
      ba.read_next = 0; ba.buf_empty = 0;
   endtask

   task automatic test_slots();
      ba.clear_addr = 1; ba.base_addr = 23'h10;
      step();
      ba.save_abs = 1; ba.save_slot = 2'd2;
      step();
      for (int i = 0; i < 5; i++) begin ba.read_next = 1; step(); end
      total++; if (ba.flash_addr !== 24'h2A) begin bad++; $display("FAIL five_cont_addr got=%0h exp=2a", ba.flash_addr); end
      ba.load_abs = 1; ba.load_slot = 2'd2;
      step();
      total++; if (ba.flash_addr !== 24'h1E) begin bad++; $display("FAIL load_slot2_addr got=%0h exp=1e", ba.flash_addr); end
      ba.save_abs = 1; ba.save_slot = 2'd1;
      step();
      ba.read_next = 1;
      step();
      // same-slot save+load: the load sees the old 0x0E, the save stores 0x0F
      ba.save_abs = 1; ba.save_slot = 2'd1; ba.load_abs = 1; ba.load_slot = 2'd1;
      step();
      total++; if (ba.flash_addr !== 24'h1C) begin bad++; $display("FAIL rbw_load_addr got=%0h exp=1c", ba.flash_addr); end
      ba.load_abs = 1; ba.load_slot = 2'd1;
      step();
      total++; if (ba.flash_addr !== 24'h1E) begin bad++; $display("FAIL rbw_saved_addr got=%0h exp=1e", ba.flash_addr); end
   endtask

   task automatic test_rel();
      ba.clear_addr = 1; ba.base_addr = 23'h20;
      step();
      ba.mark_rel = 1;
      step();
      total++; if (ba.rel_off !== 8'h1) begin bad++; $display("FAIL mark_rel got=%0h exp=1", ba.rel_off); end
      for (int i = 0; i < 3; i++) begin ba.read_next = 1; step(); end
      total++; if (ba.rel_off !== 8'h4) begin bad++; $display("FAIL rel_after_3 got=%0h exp=4", ba.rel_off); end
      total++; if (ba.flash_addr !== 24'h46) begin bad++; $display("FAIL addr_after_3 got=%0h exp=46", ba.flash_addr); end
      ba.load_rel = 1;
      step();
      total++; if (ba.flash_addr !== 24'h3E) begin bad++; $display("FAIL load_rel_addr got=%0h exp=3e", ba.flash_addr); end
      total++; if (ba.rel_off !== 8'h4) begin bad++; $display("FAIL load_rel_keeps_rel got=%0h exp=4", ba.rel_off); end
   endtask

   task automatic test_saturate();
      bb.read_next = 1;
      step();
      total++; if (bb.rel_off !== 2'h0) begin bad++; $display("FAIL start_no_rel_inc got=%0h exp=0", bb.rel_off); end
      bb.mark_rel = 1;
      step();
      for (int i = 0; i < 2; i++) begin bb.read_next = 1; step(); end
      total++; if (bb.rel_off !== 2'h3) begin bad++; $display("FAIL rel_reach_max got=%0h exp=3", bb.rel_off); end
      for (int i = 0; i < 4; i++) begin bb.read_next = 1; step(); end
      total++; if (bb.rel_off !== 2'h3) begin bad++; $display("FAIL rel_saturated got=%0h exp=3", bb.rel_off); end
      bb.mark_rel = 1; bb.read_next = 1;
      step();
      total++; if (bb.rel_off !== 2'h1) begin bad++; $display("FAIL mark_beats_inc got=%0h exp=1", bb.rel_off); end
      total++; if (bb.flash_addr !== 24'hE) begin bad++; $display("FAIL b_ptr7_addr got=%0h exp=e", bb.flash_addr); end
      bb.load_abs = 1; bb.load_slot = 2'd3; bb.read_next = 1;
      step();
      total++; if (bb.flash_addr !== 24'h10) begin bad++; $display("FAIL bad_slot_falls_through got=%0h exp=10", bb.flash_addr); end
      bb.save_abs = 1; bb.save_slot = 2'd3;
      step();
      bb.load_abs = 1; bb.load_slot = 2'd2;
      step();
      total++; if (bb.flash_addr !== 24'h0) begin bad++; $display("FAIL bad_slot_save_ignored got=%0h exp=0", bb.flash_addr); end
   endtask

   task automatic test_wrap();
      ba.clear_addr = 1; ba.base_addr = 23'h7FFFFF;
      step();
      total++; if (ba.flash_addr !== 24'hFFFFFE) begin bad++; $display("FAIL max_ptr_addr got=%0h exp=fffffe", ba.flash_addr); end
      ba.mark_rel = 1;
      step();
      ba.read_next = 1;
      step();
      total++; if (ba.flash_addr !== 24'h0) begin bad++; $display("FAIL wrap_inc_addr got=%0h exp=0", ba.flash_addr); end
      ba.read_next = 1;
      step();
      total++; if (ba.rel_off !== 8'h3) begin bad++; $display("FAIL wrap_rel got=%0h exp=3", ba.rel_off); end
      ba.load_rel = 1;
      step();
      total++; if (ba.flash_addr !== 24'hFFFFFC) begin bad++; $display("FAIL wrap_rewind_addr got=%0h exp=fffffc", ba.flash_addr); end
   endtask

   task automatic test_same_cycle();
      ba.save_abs = 1; ba.save_slot = 2'd1;
      step();
      ba.clear_addr = 1; ba.base_addr = 23'h100; ba.load_abs = 1; ba.load_slot = 2'd1; ba.read_next = 1;
      step();
      total++; if (ba.flash_addr !== 24'h200) begin bad++; $display("FAIL clear_wins_addr got=%0h exp=200", ba.flash_addr); end
      total++; if (ba.rel_off !== 8'h0) begin bad++; $display("FAIL clear_zero_rel got=%0h exp=0", ba.rel_off); end
      total++; if (ba.started !== 1'b1) begin bad++; $display("FAIL clear_keeps_started got=%0h exp=1", ba.started); end
      ba.load_abs = 1; ba.load_slot = 2'd1;
      step();
      total++; if (ba.flash_addr !== 24'h0) begin bad++; $display("FAIL clear_zero_slot got=%0h exp=0", ba.flash_addr); end
      ba.stop_read = 1; ba.read_next = 1; #1;
      total++; if (ba.spi_continue_read !== 1'b1) begin bad++; $display("FAIL stop_cycle_cont got=%0h exp=1", ba.spi_continue_read); end
      step();
      total++; if (ba.started !== 1'b0) begin bad++; $display("FAIL stop_wins got=%0h exp=0", ba.started); end
      total++; if (ba.flash_addr !== 24'h2) begin bad++; $display("FAIL stop_cycle_addr got=%0h exp=2", ba.flash_addr); end
   endtask

   task automatic test_reset_mid();
      ba.read_next = 1;
      step();
      ba.read_next = 1;
      step();
      ba.read_next = 1;
      #2;
      rst_n = 0; ba.read_next = 0;
      #1;
      total++; if (ba.started !== 1'b0) begin bad++; $display("FAIL mid_rst_started got=%0h exp=0", ba.started); end
      total++; if (ba.flash_addr !== 24'h0) begin bad++; $display("FAIL mid_rst_addr got=%0h exp=0", ba.flash_addr); end
      total++; if (ba.rel_off !== 8'h0) begin bad++; $display("FAIL mid_rst_rel got=%0h exp=0", ba.rel_off); end
      total++; if ({ba.spi_start_read, ba.spi_continue_read, ba.data_ready} !== 3'b000) begin
         bad++; $display("FAIL mid_rst_handshake got=%0b exp=000", {ba.spi_start_read, ba.spi_continue_read, ba.data_ready});
      end
      #15;
      @(negedge clk);
      rst_n = 1;
      step();
      total++; if (ba.flash_addr !== 24'h0) begin bad++; $display("FAIL after_rst_addr got=%0h exp=0", ba.flash_addr); end
   endtask

   initial begin
      test_reset();
      test_start_continue();
      test_slots();
      test_rel();
      test_saturate();
      test_wrap();
      test_same_cycle();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
